control_sequencer: RTL and testbench



---
 rtl/fpg8_ctrl_pkg.sv | 79 +++++++
 rtl/control_sequencer_if.sv | 29 ++
 rtl/control_word_decode.sv | 80 ++++++++
 rtl/control_sequencer.sv | 90 +++++++++
 tb/tb_control_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/fpg8_ctrl_pkg.sv
// rtl/fpg8_ctrl_pkg.sv - fpg8 control-unit opcodes, ALU/GPR codes, state encodings and control word
package fpg8_ctrl_pkg;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_LOAD  = 4'h1;
  localparam logic [3:0] OP_STORE = 4'h2;
  localparam logic [3:0] OP_ADD   = 4'h3;
  localparam logic [3:0] OP_SUB   = 4'h4;
  localparam logic [3:0] OP_AND   = 4'h5;
  localparam logic [3:0] OP_OR    = 4'h6;
  localparam logic [3:0] OP_XOR   = 4'h7;
  localparam logic [3:0] OP_MOV   = 4'h8;
  localparam logic [3:0] OP_HALT  = 4'hF;

  localparam logic [2:0] ALU_ADD    = 3'd0;
  localparam logic [2:0] ALU_SUB    = 3'd1;
  localparam logic [2:0] ALU_AND    = 3'd2;
  localparam logic [2:0] ALU_OR     = 3'd3;
  localparam logic [2:0] ALU_XOR    = 3'd4;
  localparam logic [2:0] ALU_NOT    = 3'd5;
  localparam logic [2:0] ALU_PASS_Y = 3'd6;
  localparam logic [2:0] ALU_INC    = 3'd7;

  localparam logic [2:0] SEL_RD1 = 3'd0;
  localparam logic [2:0] SEL_RD2 = 3'd1;
  localparam logic [2:0] SEL_RS1 = 3'd2;
  localparam logic [2:0] SEL_RS2 = 3'd3;
  localparam logic [2:0] SEL_PC  = 3'd7;

  typedef enum logic [3:0] {
    ST_F0   = 4'd0,
    ST_F1   = 4'd1,
    ST_F2   = 4'd2,
    ST_F3   = 4'd3,
    ST_E0   = 4'd4,
    ST_E1   = 4'd5,
    ST_E2   = 4'd6,
    ST_HALT = 4'd7
  } state_t;

  typedef struct packed {
    logic [2:0] alu_control;
    logic       gpr_in;
    logic       gpr_out;
    logic [2:0] gpr_select;
    logic       ir_in;
    logic       mar_in;
    logic       mdr_in;
    logic       mdr_out;
    logic       ram_read;
    logic       ram_write;
    logic       y_in;
    logic       z_in;
    logic       z_out;
  } ctrl_word_t;

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  function automatic logic has_execute(input logic [3:0] op);
    return (op >= OP_LOAD) && (op <= OP_MOV);
  endfunction

  function automatic logic is_defined_op(input logic [3:0] op);
    return (op <= OP_MOV) || (op == OP_HALT);
  endfunction

  function automatic logic [2:0] alu_for_op(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// rtl/control_sequencer_if.sv - fpg8 datapath control strobes plus the IR opcode fed back
interface control_sequencer_if;
  logic [3:0] opcode;
  logic [2:0] ALU_control;
  logic       GPR_in;
  logic       GPR_out;
  logic [2:0] GPR_select;
  logic       IR_in;
  logic       MAR_in;
  logic       MDR_in;
  logic       MDR_out;
  logic       RAM_enable_read;
  logic       RAM_enable_write;
  logic       Y_in;
  logic       Z_in;
  logic       Z_out;

  modport master (
    input  opcode,
    output ALU_control, GPR_in, GPR_out, GPR_select, IR_in, MAR_in, MDR_in, MDR_out,
           RAM_enable_read, RAM_enable_write, Y_in, Z_in, Z_out
  );

  modport slave (
    output opcode,
    input  ALU_control, GPR_in, GPR_out, GPR_select, IR_in, MAR_in, MDR_in, MDR_out,
           RAM_enable_read, RAM_enable_write, Y_in, Z_in, Z_out
  );
endinterface

// File: rtl/control_word_decode.sv
// rtl/control_word_decode.sv - combinational micro-step + opcode to datapath control word
module control_word_decode
  import fpg8_ctrl_pkg::*;
#(
  parameter logic [2:0] PC_REG = 3'd7
) (
  input  state_t     state,
  input  logic [3:0] opcode,
  input  logic       enable,
  output ctrl_word_t cw
);

  always_comb begin
    cw = '0;
    if (enable) begin
      unique case (state)
        ST_F0: begin
          cw.gpr_select  = PC_REG;
          cw.gpr_out     = 1'b1;
          cw.mar_in      = 1'b1;
          cw.alu_control = ALU_INC;
          cw.z_in        = 1'b1;
        end
        ST_F1: begin
          cw.ram_read   = 1'b1;
          cw.z_out      = 1'b1;
          cw.gpr_select = PC_REG;
          cw.gpr_in     = 1'b1;
        end
        ST_F2: begin
          cw.mdr_out = 1'b1;
          cw.ir_in   = 1'b1;
        end
        ST_E0: begin
          cw.gpr_out = 1'b1;
          if (opcode == OP_STORE) begin
            cw.gpr_select = SEL_RD1;
            cw.mar_in     = 1'b1;
          end else if (opcode == OP_LOAD) begin
            cw.gpr_select = SEL_RS1;
            cw.mar_in     = 1'b1;
          end else begin
            cw.gpr_select = SEL_RS1;
            cw.y_in       = 1'b1;
          end
        end
        ST_E1: begin
          if (is_alu_op(opcode)) begin
            cw.gpr_select  = SEL_RS2;
            cw.gpr_out     = 1'b1;
            cw.alu_control = alu_for_op(opcode);
            cw.z_in        = 1'b1;
          end else if (opcode == OP_LOAD) begin
            cw.ram_read = 1'b1;
          end else if (opcode == OP_STORE) begin
            cw.gpr_select = SEL_RS1;
            cw.gpr_out    = 1'b1;
            cw.mdr_in     = 1'b1;
          end else begin
            cw.alu_control = ALU_PASS_Y;
            cw.z_in        = 1'b1;
          end
        end
        ST_E2: begin
          if (opcode == OP_STORE) begin
            cw.ram_write = 1'b1;
          end else begin
            // LOAD writes back from MDR, everything else from Z
            cw.gpr_select = SEL_RD1;
            cw.gpr_in     = 1'b1;
            cw.mdr_out    = (opcode == OP_LOAD);
            cw.z_out      = (opcode != OP_LOAD);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - fpg8 hardwired control unit: fetch/decode/execute sequencer
module control_sequencer
  import fpg8_ctrl_pkg::*;
#(
  parameter logic [2:0] PC_REG = 3'd7,
  parameter int         CNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               step_en,
  control_sequencer_if.master bus,
  output logic               halted,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   instr_count,
  output logic [3:0]         state_out
);

  state_t     state_q, state_d;
  logic       retire;
  ctrl_word_t cw;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_F0;
      illegal_op  <= 1'b0;
      instr_count <= '0;
    end else if (step_en) begin
      state_q <= state_d;
      if (retire)
        instr_count <= instr_count + CNT_W'(1);
      if (state_q == ST_F3 && !is_defined_op(bus.opcode))
        illegal_op <= 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    retire  = 1'b0;
    unique case (state_q)
      ST_F0: state_d = ST_F1;
      ST_F1: state_d = ST_F2;
      ST_F2: state_d = ST_F3;
      ST_F3: begin
        if (bus.opcode == OP_HALT) begin
          state_d = ST_HALT;
        end else if (has_execute(bus.opcode)) begin
          state_d = ST_E0;
        end else begin
          // NOP and undefined opcodes retire straight out of decode
          state_d = ST_F0;
          retire  = 1'b1;
        end
      end
      ST_E0: state_d = ST_E1;
      ST_E1: state_d = ST_E2;
      ST_E2: begin
        state_d = ST_F0;
        retire  = 1'b1;
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_F0;
    endcase
  end

  // Strobes are held off while frozen and while reset is asserted
  control_word_decode #(.PC_REG(PC_REG)) u_decode (
    .state  (state_q),
    .opcode (bus.opcode),
    .enable (step_en & reset),
    .cw     (cw)
  );

  assign bus.ALU_control      = cw.alu_control;
  assign bus.GPR_in           = cw.gpr_in;
  assign bus.GPR_out          = cw.gpr_out;
  assign bus.GPR_select       = cw.gpr_select;
  assign bus.IR_in            = cw.ir_in;
  assign bus.MAR_in           = cw.mar_in;
  assign bus.MDR_in           = cw.mdr_in;
  assign bus.MDR_out          = cw.mdr_out;
  assign bus.RAM_enable_read  = cw.ram_read;
  assign bus.RAM_enable_write = cw.ram_write;
  assign bus.Y_in             = cw.y_in;
  assign bus.Z_in             = cw.z_in;
  assign bus.Z_out            = cw.z_out;

  assign halted    = (state_q == ST_HALT);
  assign state_out = state_q;

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - directed and randomized bench for control_sequencer
module tb_control_sequencer;
  import fpg8_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        step_en = 1'b0;
  logic        halted;
  logic        illegal_op;
  logic [15:0] instr_count;
  logic [3:0]  state_out;

  control_sequencer_if bus();

  control_sequencer #(.PC_REG(3'd7), .CNT_W(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .step_en     (step_en),
    .bus         (bus.master),
    .halted      (halted),
    .illegal_op  (illegal_op),
    .instr_count (instr_count),
    .state_out   (state_out)
  );

  always #5 clk = ~clk;

  int         vectors = 0;
  int         miscompares = 0;
  int         m_step;
  int         m_count;
  bit         m_ill;
  bit         m_halt;
  logic [3:0] cur_op;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  // Instruction length in enabled clocks: 4 for fetch+decode only, 7 with execute
  function automatic int instr_len(input logic [3:0] op);
    return (op >= 4'd1 && op <= 4'd8) ? 7 : 4;
  endfunction

  // Expected control word for micro-step index st (0..6) of an instruction; -1 means no strobes
  function automatic logic [16:0] exp_word(input int st, input logic [3:0] op, input bit en);
    logic [2:0] alu, sel;
    logic gi, go, ir, mar, mdi, mdo, rd, wr, y, zi, zo;
    bit alu_op;
    alu = 3'd0; sel = 3'd0;
    {gi, go, ir, mar, mdi, mdo, rd, wr, y, zi, zo} = '0;
    alu_op = (op >= 4'd3 && op <= 4'd7);
    if (en) begin
      if (st == 0) begin sel = 3'd7; go = 1; mar = 1; alu = 3'd7; zi = 1; end
      if (st == 1) begin rd = 1; zo = 1; sel = 3'd7; gi = 1; end
      if (st == 2) begin mdo = 1; ir = 1; end
      if (st == 4) begin
        go = 1;
        sel = (op == 4'd2) ? 3'd0 : 3'd2;
        if (op == 4'd1 || op == 4'd2) mar = 1; else y = 1;
      end
      if (st == 5) begin
        if (alu_op) begin sel = 3'd3; go = 1; alu = 3'(op - 4'd3); zi = 1; end
        else if (op == 4'd1) rd = 1;
        else if (op == 4'd2) begin sel = 3'd2; go = 1; mdi = 1; end
        else begin alu = 3'd6; zi = 1; end
      end
      if (st == 6) begin
        if (op == 4'd2) wr = 1;
        else begin
          sel = 3'd0; gi = 1;
          if (op == 4'd1) mdo = 1; else zo = 1;
        end
      end
    end
    return {alu, gi, go, sel, ir, mar, mdi, mdo, rd, wr, y, zi, zo};
  endfunction

  function automatic logic [16:0] obs_word();
    return {bus.ALU_control, bus.GPR_in, bus.GPR_out, bus.GPR_select, bus.IR_in, bus.MAR_in,
            bus.MDR_in, bus.MDR_out, bus.RAM_enable_read, bus.RAM_enable_write,
            bus.Y_in, bus.Z_in, bus.Z_out};
  endfunction

  function automatic logic [3:0] exp_state();
    state_t steps [7] = '{ST_F0, ST_F1, ST_F2, ST_F3, ST_E0, ST_E1, ST_E2};
    if (m_halt) return ST_HALT;
    return steps[m_step];
  endfunction

  task automatic check_outputs();
    chk("strobes", 32'(obs_word()), 32'(exp_word(m_halt ? -1 : m_step, cur_op, step_en && reset)));
    chk("state_out", 32'(state_out), 32'(exp_state()));
    chk("instr_count", 32'(instr_count), 32'(m_count));
    chk("illegal_op", 32'(illegal_op), 32'(m_ill));
    chk("halted", 32'(halted), 32'(m_halt));
    chk("one_bus_driver", 32'((bus.GPR_out & bus.MDR_out) | (bus.GPR_out & bus.Z_out) |
                              (bus.MDR_out & bus.Z_out)), 32'd0);
    chk("ram_rd_wr", 32'(bus.RAM_enable_read & bus.RAM_enable_write), 32'd0);
    chk("mdr_in_vs_ram_rd", 32'(bus.MDR_in & bus.RAM_enable_read), 32'd0);
  endtask

  task automatic model_reset();
    m_step = 0; m_count = 0; m_ill = 0; m_halt = 0;
  endtask

  task automatic model_advance(input bit en);
    if (!en || m_halt) return;
    if (m_step == 3 && !(cur_op <= 4'd8 || cur_op == 4'hF)) m_ill = 1;
    if (m_step == 3 && cur_op == 4'hF) m_halt = 1;
    else if (m_step == instr_len(cur_op) - 1) begin
      m_count = (m_count + 1) & 16'hFFFF;
      m_step  = 0;
    end else m_step++;
  endtask

  // Starts and ends one sample after a rising edge
  task automatic cycle(input logic [3:0] op, input bit en);
    bus.opcode = op;
    cur_op     = op;
    step_en    = en;
    #1;
    check_outputs();
    @(posedge clk);
    #1;
    model_advance(en);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;
  endtask

  initial begin
    bus.opcode = 4'h0;
    cur_op     = 4'h0;
    model_reset();

    do_reset();
    repeat (4) cycle(4'h0, 1'b1);
    chk("nop_retired", 32'(instr_count), 32'd1);
    chk("nop_back_f0", 32'(state_out), 32'(ST_F0));

    do_reset();
    repeat (7) cycle(4'h3, 1'b1);
    chk("add_retired", 32'(instr_count), 32'd1);

    do_reset();
    repeat (7) cycle(4'h2, 1'b1);
    chk("store_retired", 32'(instr_count), 32'd1);

    do_reset();
    repeat (5) cycle(4'h1, 1'b1);
    repeat (3) cycle(4'h1, 1'b0);
    chk("load_frozen_e1", 32'(state_out), 32'(ST_E1));
    repeat (2) cycle(4'h1, 1'b1);
    chk("load_retired_10clk", 32'(instr_count), 32'd1);
    chk("load_back_f0", 32'(state_out), 32'(ST_F0));

    do_reset();
    repeat (4) cycle(4'hB, 1'b1);
    chk("undef_sticky", 32'(illegal_op), 32'd1);
    chk("undef_retired", 32'(instr_count), 32'd1);
    repeat (4) cycle(4'hF, 1'b1);
    chk("halt_entered", 32'(halted), 32'd1);
    repeat (3) cycle(4'h3, 1'b1);
    chk("halt_stays", 32'(halted), 32'd1);
    chk("halt_count_frozen", 32'(instr_count), 32'd1);

    // Asynchronous reset midway through E1 of a MOV, after one retired instruction
    do_reset();
    repeat (4) cycle(4'hB, 1'b1);
    repeat (5) cycle(4'h8, 1'b1);
    chk("mov_in_e1", 32'(state_out), 32'(ST_E1));
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_state", 32'(state_out), 32'(ST_F0));
    chk("async_count", 32'(instr_count), 32'd0);
    chk("async_illegal", 32'(illegal_op), 32'd0);
    chk("async_strobes", 32'(obs_word()), 32'd0);
    @(posedge clk);
    #1;
    check_outputs();
    reset = 1'b1;

    // Randomized instruction stream; opcode is held for the life of each instruction
    do_reset();
    for (int i = 0; i < 400; i++) begin
      logic [3:0] op;
      op = (m_step == 0) ? 4'($urandom_range(0, 14)) : cur_op;
      cycle(op, ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
